// File: rtl/prco_uart_tx_if.sv
// Byte-write and status bundle between the core and the UART transmitter.
// Signal names match the original port list so existing connections carry over.
interface prco_uart_tx_if;
  logic       i_ce;
  logic [7:0] i_byte;
  logic       q_tx;
  logic       q_full;
  logic       q_empty;
  logic [4:0] q_count;
  logic       q_busy;
  logic       q_overflow;

  modport master (
    output i_ce, i_byte,
    input  q_tx, q_full, q_empty, q_count, q_busy, q_overflow
  );

  modport slave (
    input  i_ce, i_byte,
    output q_tx, q_full, q_empty, q_count, q_busy, q_overflow
  );
endinterface

// File: rtl/prco_uart_tx.sv
// UART transmitter (8N1, LSB first) fed by a small byte FIFO.
// Every output is a flop; FIFO status flags are registered alongside the count.
module prco_uart_tx #(
  parameter int unsigned CLK_DIV    = 434,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  prco_uart_tx_if.slave bus
);

  localparam int unsigned PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);
  localparam logic [4:0]  DEPTH_CNT = 5'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [4:0]       count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             ovf_q, ovf_d;
  state_e           state_q, state_d;
  logic [15:0]      baud_q, baud_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             push;
  logic             pop;
  logic             baud_end;

  always_comb begin
    push      = bus.i_ce && !full_q;
    pop       = 1'b0;
    baud_end  = (baud_q == BAUD_LAST);
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    tx_d      = tx_q;

    // tx_d is the line level for the state being entered, so q_tx changes on the same edge as the state
    unique case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (!empty_q) begin
          pop     = 1'b1;
          shreg_d = mem[rd_ptr_q];
          baud_d  = '0;
          state_d = S_START;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (baud_end) begin
          baud_d    = '0;
          bit_idx_d = '0;
          state_d   = S_DATA;
          tx_d      = shreg_q[0];
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            shreg_d   = shreg_q >> 1;
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shreg_q[1];
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      S_STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (!empty_q) begin
            pop     = 1'b1;
            shreg_d = mem[rd_ptr_q];
            state_d = S_START;
            tx_d    = 1'b0;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    busy_d   = (state_d != S_IDLE);
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase
    full_d  = (count_d == DEPTH_CNT);
    empty_d = (count_d == 5'd0);
    ovf_d   = bus.i_ce && full_q;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      ovf_q     <= 1'b0;
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      ovf_q     <= ovf_d;
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers and count.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr_q] <= bus.i_byte;
    end
  end

  assign bus.q_tx       = tx_q;
  assign bus.q_full     = full_q;
  assign bus.q_empty    = empty_q;
  assign bus.q_count    = count_q;
  assign bus.q_busy     = busy_q;
  assign bus.q_overflow = ovf_q;

endmodule

// File: tb/tb_prco_uart_tx.sv
// Randomised bench for prco_uart_tx against a frame-position reference model
// (byte queue plus position inside a 10-bit 8N1 frame).
module tb_prco_uart_tx;

  localparam int CD    = 4;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  prco_uart_tx_if bus ();

  prco_uart_tx #(
    .CLK_DIV   (CD),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .i_clk    (clk),
    .i_reset_n(rst_n),
    .bus      (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [7:0] mq[$];
  bit         m_active;
  int         m_pos;
  logic [7:0] m_cur;
  bit         m_ovf;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    m_active = 1'b0;
    m_pos    = 0;
    m_cur    = '0;
    m_ovf    = 1'b0;
  endfunction

  // One clock edge: decisions use occupancy as it was before the edge.
  function automatic void model_edge(input bit ce, input logic [7:0] b);
    int sz;
    bit full_pre;
    bit ne_pre;
    sz       = mq.size();
    full_pre = (sz == DEPTH);
    ne_pre   = (sz != 0);
    m_ovf    = ce && full_pre;
    if (m_active) begin
      m_pos++;
      if (m_pos == 10 * CD) begin
        if (ne_pre) begin
          m_cur = mq.pop_front();
          m_pos = 0;
        end else begin
          m_active = 1'b0;
        end
      end
    end else if (ne_pre) begin
      m_cur    = mq.pop_front();
      m_active = 1'b1;
      m_pos    = 0;
    end
    if (ce && !full_pre) mq.push_back(b);
  endfunction

  function automatic logic exp_tx();
    int slot;
    if (!m_active) return 1'b1;
    slot = m_pos / CD;
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return m_cur[slot-1];
  endfunction

  task automatic compare_all();
    int sz;
    sz = mq.size();
    check_eq("tx",       bus.q_tx,       exp_tx());
    check_eq("count",    bus.q_count,    sz);
    check_eq("full",     bus.q_full,     sz == DEPTH);
    check_eq("empty",    bus.q_empty,    sz == 0);
    check_eq("busy",     bus.q_busy,     m_active);
    check_eq("overflow", bus.q_overflow, m_ovf);
  endtask

  task automatic cycle(input bit ce, input logic [7:0] b);
    @(negedge clk);
    bus.i_ce   = ce;
    bus.i_byte = b;
    @(posedge clk);
    model_edge(ce, b);
    #1;
    compare_all();
  endtask

  task automatic drain();
    for (int i = 0; i < 5000 && (m_active || mq.size() != 0); i++) cycle(1'b0, 8'h00);
    check_eq("drained_idle", bus.q_busy, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_tx"},    bus.q_tx,       1'b1);
    check_eq({tag, "_full"},  bus.q_full,     1'b0);
    check_eq({tag, "_empty"}, bus.q_empty,    1'b1);
    check_eq({tag, "_count"}, bus.q_count,    5'd0);
    check_eq({tag, "_busy"},  bus.q_busy,     1'b0);
    check_eq({tag, "_ovf"},   bus.q_overflow, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int maxc;
    int idx;
    int rate;
    rst_n      = 1'b0;
    bus.i_ce   = 1'b0;
    bus.i_byte = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Single byte 0x41
    cycle(1'b1, 8'h41);
    check_eq("single_fall", bus.q_tx, 1'b1);
    cycle(1'b0, 8'h00);
    check_eq("single_start", bus.q_tx, 1'b0);
    drain();

    // Back-to-back frames, counting busy cycles
    cnt = 0;
    cycle(1'b1, 8'h55);
    if (bus.q_busy) cnt++;
    cycle(1'b1, 8'hA3);
    if (bus.q_busy) cnt++;
    for (int i = 0; i < 100; i++) begin
      cycle(1'b0, 8'h00);
      if (bus.q_busy) cnt++;
    end
    check_eq("b2b_busy_cycles", cnt, 80);

    // Fill while a frame is in flight: 9 writes, the 9th is dropped
    cycle(1'b1, 8'h11);
    repeat (3) cycle(1'b0, 8'h00);
    cnt = 0;
    for (int i = 0; i < 9; i++) begin
      cycle(1'b1, 8'(8'h20 + i));
      if (bus.q_overflow) cnt++;
    end
    cycle(1'b0, 8'h00);
    if (bus.q_overflow) cnt++;
    check_eq("fill_count", bus.q_count, 5'd8);
    check_eq("fill_full", bus.q_full, 1'b1);
    cycle(1'b0, 8'h00);
    if (bus.q_overflow) cnt++;
    check_eq("fill_ovf_pulses", cnt, 1);
    drain();

    // Pointer wrap: 20 bytes in bursts of 6 with draining between
    maxc = 0;
    idx  = 0;
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 6 && idx < 20; i++) begin
        cycle(1'b1, 8'($urandom));
        idx++;
        if (int'(bus.q_count) > maxc) maxc = bus.q_count;
      end
      for (int i = 0; i < 240; i++) begin
        cycle(1'b0, 8'h00);
        if (int'(bus.q_count) > maxc) maxc = bus.q_count;
      end
    end
    check_eq("wrap_count_bound", maxc <= DEPTH, 1'b1);

    // Push/pop collision at end of STOP with three queued
    cycle(1'b1, 8'hC1);
    cycle(1'b1, 8'hC2);
    cycle(1'b1, 8'hC3);
    cycle(1'b1, 8'hC4);
    for (int i = 0; i < 100 && m_pos != 10 * CD - 1; i++) cycle(1'b0, 8'h00);
    check_eq("collide_pre_count", bus.q_count, 5'd3);
    cycle(1'b1, 8'hC5);
    check_eq("collide_count", bus.q_count, 5'd3);
    drain();

    // Reset during data bit 3 (0x37 has bit 3 low, so the line is low there)
    cycle(1'b1, 8'h37);
    for (int i = 0; i < 100 && !(m_active && (m_pos / CD) == 4); i++) cycle(1'b0, 8'h00);
    check_eq("pre_reset_tx", bus.q_tx, 1'b0);
    #2;
    rst_n    = 1'b0;
    bus.i_ce = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    model_reset();
    @(posedge clk);
    #1;
    check_reset_outputs("held_reset");
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 8'h0F);
    cycle(1'b0, 8'h00);
    check_eq("post_reset_start", bus.q_tx, 1'b0);
    drain();

    // Randomised traffic, alternating heavy and light write rates
    for (int i = 0; i < 3000; i++) begin
      rate = ((i / 500) % 2 == 0) ? 4 : 40;
      cycle($urandom_range(0, rate - 1) == 0, 8'($urandom));
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
